// File: rtl/add_acc_pipe.sv
// Two-stage valid/ready adder with a saturating accumulate mode and a
// delivered-result counter. S1 holds operands, S2 holds the registered result.
module add_acc_pipe #(
  parameter int WIDTH = 4,
  parameter int ACC_W = WIDTH + 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic [CNT_W-1:0] txn_count
);

  // Two guard bits so base + a + b can never wrap before the saturation test.
  localparam int TW = ACC_W + 2;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_ACC = 1'b1
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             clr;
  } s1_t;

  logic             v1;
  logic             v2;
  s1_t              s1;
  logic [ACC_W-1:0] acc;

  logic             s1_load;
  logic             s2_load;
  logic [TW-1:0]    base_ext;
  logic [TW-1:0]    total;
  logic [ACC_W-1:0] res;
  logic             res_ovf;

  // Handshake: a stalled consumer closes in_ready in the same cycle.
  always_comb begin
    s2_load   = v1 && (!v2 || out_ready);
    in_ready  = !rst && (!v1 || s2_load);
    s1_load   = in_valid && in_ready;
    out_valid = v2 && !rst;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    res      = '0;
    res_ovf  = 1'b0;
    base_ext = s1.clr ? '0 : TW'(acc);
    total    = base_ext + TW'(s1.a) + TW'(s1.b);
    if (s1.op == OP_ACC) begin
      if (total > TW'(ACC_MAX)) begin
        res     = ACC_MAX;
        res_ovf = 1'b1;
      end else begin
        res = total[ACC_W-1:0];
      end
    end else begin
      res = ACC_W'(s1.a) + ACC_W'(s1.b);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (s1_load) begin
      v1 <= 1'b1;
    end else if (s2_load) begin
      v1 <= 1'b0;
    end
  end

  // NOTE: the operand register carries no reset; it is only read while v1 is
  // set, and v1 is always reset.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1 <= '{a: a, b: b, op: op_e'(mode), clr: clr_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      sum <= '0;
      ovf <= 1'b0;
    end else if (s2_load) begin
      v2  <= 1'b1;
      sum <= res;
      ovf <= res_ovf;
    end else if (out_ready) begin
      v2 <= 1'b0;
    end
  end

  // The accumulator moves only when an accumulate result enters S2, so stalls hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (s2_load && s1.op == OP_ACC) begin
      acc <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_add_acc_pipe.sv
// Directed bench for add_acc_pipe: add, saturating accumulate, backpressure,
// mixed mode, mid-operation reset and counter wrap with hand-computed results.
module tb_add_acc_pipe;

  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             clr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic [CNT_W-1:0] txn_count;

  add_acc_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .clr_acc(clr_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] s;
    logic             o;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, advance past the rising edge.
  task automatic tick(output bit accepted);
    exp_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_result: observed sum %0h expected no result", sum);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result_sum", sum, e.s);
        chk("result_ovf", ovf, e.o);
      end
      exp_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] ta, input logic [3:0] tb_, input logic tm,
                      input logic tc, input logic [7:0] es, input logic eo);
    bit acc_f;
    int k;
    exp_t e;
    in_valid = 1'b1; a = ta; b = tb_; mode = tm; clr_acc = tc;
    acc_f = 1'b0;
    k = 0;
    while (!acc_f && k < 40) begin
      tick(acc_f);
      k++;
    end
    chk("accept_timeout", acc_f, 1);
    e.s = es;
    e.o = eo;
    if (acc_f) exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit dummy;
    int k;
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick(dummy);
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bit dummy;
    rst = 1'b1;
    in_valid = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    tick(dummy);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  initial begin
    bit dummy;
    int c0;
    logic [7:0] sat_exp [10];
    sat_exp = '{8'd30, 8'd60, 8'd90, 8'd120, 8'd150, 8'd180, 8'd210, 8'd240, 8'd255, 8'd255};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; clr_acc = 1'b0;
    out_ready = 1'b1; exp_cnt = '0;
    tick(dummy);
    do_reset();
    #2;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_count", txn_count, 0);

    // Add mode: latency 2, back-to-back delivery.
    c0 = cyc;
    send(4'd4, 4'd4, 1'b0, 1'b0, 8'd8, 1'b0);
    chk("lat_after_accept", out_valid, 0);
    send(4'd3, 4'd4, 1'b0, 1'b0, 8'd7, 1'b0);
    chk("lat_next_edge", out_valid, 1);
    chk("lat_sum", sum, 8'd8);
    send(4'd3, 4'd7, 1'b0, 1'b0, 8'd10, 1'b0);
    drain();
    chk("add_cycles", cyc - c0, 5);
    chk("add_count", txn_count, 3);
    send(4'd15, 4'd15, 1'b0, 1'b0, 8'd30, 1'b0);
    drain();

    // Accumulate up to saturation, then restart from zero.
    for (int i = 0; i < 10; i++)
      send(4'd15, 4'd15, 1'b1, (i == 0), sat_exp[i], (i >= 8));
    send(4'd1, 4'd1, 1'b1, 1'b1, 8'd2, 1'b0);
    drain();
    chk("acc_count", txn_count, exp_cnt);

    // Backpressure: two accepted, then in_ready drops while S2 holds.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'd1; b = 4'd1; mode = 1'b0; clr_acc = 1'b0;
    #2 chk("bp_ready1", in_ready, 1);
    tick(dummy);
    exp_q.push_back('{s: 8'd2, o: 1'b0});
    a = 4'd2; b = 4'd2;
    #2 chk("bp_ready2", in_ready, 1);
    tick(dummy);
    exp_q.push_back('{s: 8'd4, o: 1'b0});
    a = 4'd3; b = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_ready_low", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 8'd2);
      tick(dummy);
    end
    out_ready = 1'b1;
    c0 = cyc;
    send(4'd3, 4'd3, 1'b0, 1'b0, 8'd6, 1'b0);
    send(4'd4, 4'd4, 1'b0, 1'b0, 8'd8, 1'b0);
    drain();
    chk("bp_stream_cycles", cyc - c0, 4);

    // Mixed: the add must not disturb the accumulator.
    send(4'd5, 4'd5, 1'b1, 1'b1, 8'd10, 1'b0);
    send(4'd9, 4'd9, 1'b0, 1'b0, 8'd18, 1'b0);
    send(4'd1, 4'd0, 1'b1, 1'b0, 8'd11, 1'b0);
    drain();

    // Reset mid-operation with acc=100 and two results in flight.
    send(4'd15, 4'd15, 1'b1, 1'b1, 8'd30, 1'b0);
    send(4'd15, 4'd15, 1'b1, 1'b0, 8'd60, 1'b0);
    send(4'd15, 4'd15, 1'b1, 1'b0, 8'd90, 1'b0);
    send(4'd5, 4'd5, 1'b1, 1'b0, 8'd100, 1'b0);
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'd1; b = 4'd1; mode = 1'b1; clr_acc = 1'b0;
    tick(dummy);
    tick(dummy);
    #2;
    chk("inflight_ready", in_ready, 0);
    chk("inflight_valid", out_valid, 1);
    do_reset();
    #2;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_count", txn_count, 0);
    chk("midrst_ready", in_ready, 1);
    out_ready = 1'b1;
    send(4'd1, 4'd1, 1'b1, 1'b0, 8'd2, 1'b0);
    drain();
    chk("midrst_count1", txn_count, 1);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic [3:0] ai;
      ai = 4'(i);
      send(ai, 4'd1, 1'b0, 1'b0, 8'(ai) + 8'd1, 1'b0);
    end
    drain();
    chk("wrap_count", txn_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
